// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if
// Bundles the read, writeback and issue signals of the regfile_sb register file.
//
// Signals:
//   rd0_addr/rd1_addr  read port addresses (master -> slave)
//   rd0_data/rd1_data  combinational read data (slave -> master)
//   rd0_busy/rd1_busy  addressed register has a pending producer (slave -> master)
//   wr_en/wr_addr/wr_data  writeback port (master -> slave)
//   iss_en/iss_addr    an instruction writing iss_addr enters the pipeline
//   sb_err             sticky scoreboard overflow flag (slave -> master)
//
// Modports:
//   master  decode/writeback side that drives the requests
//   slave   the register file
// ----------------------------------------------------------------------------
interface regfile_sb_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] rd0_addr;
   logic [WIDTH-1:0]  rd0_data;
   logic              rd0_busy;
   logic [ADDR_W-1:0] rd1_addr;
   logic [WIDTH-1:0]  rd1_data;
   logic              rd1_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              sb_err;

   modport master (
      output rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd0_data, rd0_busy, rd1_data, rd1_busy, sb_err
   );

   modport slave (
      input  rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd0_data, rd0_busy, rd1_data, rd1_busy, sb_err
   );
endinterface

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// GPR array for the pipelined LC-3 datapath: two asynchronous read ports, one
// synchronous writeback port, optional writeback-to-read forwarding, and a
// per-register pending-write counter that lets decode detect RAW hazards.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (registers, counters, sb_err cleared)
//   bus  regfile_sb_if.slave: read ports, writeback, issue, sb_err
//
// The block never stalls on its own; the consumer gates iss_en on rdN_busy.
// ----------------------------------------------------------------------------
module regfile_sb #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 2,
   parameter int BYPASS = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [CNT_W-1:0] cnt_q  [DEPTH];
   logic [CNT_W-1:0] cnt_d  [DEPTH];
   logic             err_q;
   logic             err_d;

   logic             fwd0;
   logic             fwd1;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   // A writeback hitting the read address is forwarded only when enabled.
   assign fwd0 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd0_addr);
   assign fwd1 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd1_addr);

   assign bus.rd0_data = fwd0 ? bus.wr_data : regs_q[bus.rd0_addr];
   assign bus.rd1_data = fwd1 ? bus.wr_data : regs_q[bus.rd1_addr];

   assign cnt0 = cnt_q[bus.rd0_addr];
   assign cnt1 = cnt_q[bus.rd1_addr];

   // A forwarded writeback retires one producer already this cycle; the
   // cnt!=0 guard keeps an untracked write from wrapping the subtraction.
   assign bus.rd0_busy = (cnt0 - CNT_W'(fwd0 && (cnt0 != '0))) != '0;
   assign bus.rd1_busy = (cnt1 - CNT_W'(fwd1 && (cnt1 != '0))) != '0;

   assign bus.sb_err = err_q;

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < DEPTH; i++) begin
         logic inc;
         logic dec;
         inc      = bus.iss_en && (bus.iss_addr == ADDR_W'(i));
         dec      = bus.wr_en && (bus.wr_addr == ADDR_W'(i)) && (cnt_q[i] != '0);
         cnt_d[i] = cnt_q[i];
         if (inc && !dec) begin
            // Saturate instead of wrapping so busy can never falsely clear.
            if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (dec && !inc) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         if (bus.wr_en) regs_q[bus.wr_addr] <= bus.wr_data;
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
         err_q <= err_d;
      end
   end
endmodule
